// File: rtl/wb_bridge_master.sv
// Wishbone single-cycle master fed by a small command FIFO.
// Each queued command becomes one bus cycle and then one response. A per-cycle
// ACK timeout keeps a hung slave from stalling the queue.
module wb_bridge_master #(
    parameter int ADDRWIDTH      = 17,
    parameter int DATAWIDTH      = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 WB_CLK,
    input  logic                 WB_RST,
    // command side
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADDRWIDTH-1:0] cmd_adr,
    input  logic [3:0]           cmd_byte_stb,
    input  logic [DATAWIDTH-1:0] cmd_wdat,
    // response side
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_we,
    output logic [DATAWIDTH-1:0] rsp_rdat,
    output logic                 rsp_err,
    // Wishbone master side
    output logic [ADDRWIDTH-1:0] WBs_ADR_o,
    output logic                 WBs_CYC_o,
    output logic                 WBs_STB_o,
    output logic                 WBs_WE_o,
    output logic                 WBs_RD_o,
    output logic [3:0]           WBs_BYTE_STB_o,
    output logic [DATAWIDTH-1:0] WBs_WR_DAT_o,
    input  logic [DATAWIDTH-1:0] WBs_RD_DAT_i,
    input  logic                 WBs_ACK_i,
    output logic                 busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [15:0]  TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic                 we;
        logic [ADDRWIDTH-1:0] adr;
        logic [3:0]           stb;
        logic [DATAWIDTH-1:0] wdat;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t            state, state_next;
    cmd_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              full, empty, push, pop;
    logic              bus_we;
    logic [15:0]       to_cnt;
    logic              bus_ok, bus_timeout;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign cmd_ready = ~full;
    assign push      = cmd_valid & ~full;

    // Queue storage: data only, qualified by the pointers and count.
    // NOTE: storage array has no reset; count==0 already marks every entry invalid,
    // and leaving it out keeps the array mappable to plain RAM/flops without reset.
    always_ff @(posedge WB_CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{we: cmd_we, adr: cmd_adr, stb: cmd_byte_stb, wdat: cmd_wdat};
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally because depth is a power of 2.
    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode plus the one-cycle strobes that steer the datapath.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        bus_ok      = 1'b0;
        bus_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                if (WBs_ACK_i) begin
                    bus_ok     = 1'b1;
                    state_next = RESP;
                end else if (to_cnt == TO_LAST) begin
                    bus_timeout = 1'b1;
                    state_next  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus command registers, timeout counter and response capture.
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            bus_we         <= 1'b0;
            WBs_ADR_o      <= '0;
            WBs_BYTE_STB_o <= '0;
            WBs_WR_DAT_o   <= '0;
            to_cnt         <= '0;
            rsp_we         <= 1'b0;
            rsp_rdat       <= '0;
            rsp_err        <= 1'b0;
        end else begin
            if (pop) begin
                bus_we         <= fifo_mem[rd_ptr].we;
                WBs_ADR_o      <= fifo_mem[rd_ptr].adr;
                WBs_BYTE_STB_o <= fifo_mem[rd_ptr].stb;
                WBs_WR_DAT_o   <= fifo_mem[rd_ptr].wdat;
                to_cnt         <= '0;
            end else if (state == BUS && !WBs_ACK_i && to_cnt != TO_LAST) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (bus_ok) begin
                rsp_we   <= bus_we;
                rsp_rdat <= bus_we ? '0 : WBs_RD_DAT_i;
                rsp_err  <= 1'b0;
            end else if (bus_timeout) begin
                rsp_we   <= bus_we;
                rsp_rdat <= '0;
                rsp_err  <= 1'b1;
            end
        end
    end

    // Bus controls are a decode of the registered state, so they drop on the
    // same edge that leaves BUS (ACK, timeout or reset).
    assign WBs_CYC_o = (state == BUS);
    assign WBs_STB_o = (state == BUS);
    assign WBs_WE_o  = (state == BUS) &  bus_we;
    assign WBs_RD_o  = (state == BUS) & ~bus_we;
    assign rsp_valid = (state == RESP);
    assign busy_o    = (state != IDLE) | ~empty;

endmodule

// File: tb/tb_wb_bridge_master.sv
// Directed bench for wb_bridge_master: a scoreboard holds expected bus cycles and
// responses; independent monitors compare what the DUT actually presents.
module tb_wb_bridge_master;

    localparam int AW = 17;
    localparam int DW = 32;

    logic          WB_CLK = 1'b0;
    logic          WB_RST;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [3:0]    cmd_byte_stb;
    logic [DW-1:0] cmd_wdat;
    logic          rsp_valid, rsp_ready, rsp_we, rsp_err;
    logic [DW-1:0] rsp_rdat;
    logic [AW-1:0] WBs_ADR_o;
    logic          WBs_CYC_o, WBs_STB_o, WBs_WE_o, WBs_RD_o;
    logic [3:0]    WBs_BYTE_STB_o;
    logic [DW-1:0] WBs_WR_DAT_o, WBs_RD_DAT_i;
    logic          WBs_ACK_i;
    logic          busy_o;

    wb_bridge_master #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .WB_CLK(WB_CLK), .WB_RST(WB_RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
        .cmd_byte_stb(cmd_byte_stb), .cmd_wdat(cmd_wdat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdat(rsp_rdat), .rsp_err(rsp_err),
        .WBs_ADR_o(WBs_ADR_o), .WBs_CYC_o(WBs_CYC_o), .WBs_STB_o(WBs_STB_o),
        .WBs_WE_o(WBs_WE_o), .WBs_RD_o(WBs_RD_o), .WBs_BYTE_STB_o(WBs_BYTE_STB_o),
        .WBs_WR_DAT_o(WBs_WR_DAT_o), .WBs_RD_DAT_i(WBs_RD_DAT_i), .WBs_ACK_i(WBs_ACK_i),
        .busy_o(busy_o)
    );

    always #5 WB_CLK = ~WB_CLK;

    // Expected bus cycle: what the master must drive and how the slave answers.
    // delay = wait cycles before ACK (-1 = never); exp_len = CYC-high cycles (0 = don't check).
    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [3:0]    stb;
        logic [DW-1:0] wdat;
        int            delay;
        logic [DW-1:0] rdat;
        int            exp_len;
    } bus_t;

    typedef struct {
        logic          we;
        logic          err;
        logic [DW-1:0] rdat;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];

    int total = 0;
    int bad   = 0;
    int rises = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model and bus monitor, both working on the falling edge.
    bus_t cur;
    logic cyc_prev = 1'b0;
    int   cyc_len  = 0;
    logic stable_ok;

    initial begin
        WBs_ACK_i    = 1'b0;
        WBs_RD_DAT_i = 32'hDEAD_BEEF;
    end

    always @(negedge WB_CLK) begin
        if (WBs_CYC_o) begin
            if (!cyc_prev) begin
                rises++;
                cyc_len   = 0;
                stable_ok = 1'b1;
                if (bus_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_bus_cycle: adr=%0h", WBs_ADR_o);
                    cur = '{we: WBs_WE_o, adr: WBs_ADR_o, stb: WBs_BYTE_STB_o, wdat: WBs_WR_DAT_o,
                            delay: 0, rdat: '0, exp_len: 0};
                end else begin
                    cur = bus_q.pop_front();
                    check("bus_adr", 64'(WBs_ADR_o), 64'(cur.adr));
                    check("bus_we",  64'(WBs_WE_o),  64'(cur.we));
                    check("bus_rd",  64'(WBs_RD_o),  64'(!cur.we));
                    check("bus_stb", 64'(WBs_STB_o), 64'd1);
                    check("bus_bstb", 64'(WBs_BYTE_STB_o), 64'(cur.stb));
                    if (cur.we) check("bus_wdat", 64'(WBs_WR_DAT_o), 64'(cur.wdat));
                end
            end
            cyc_len++;
            if (WBs_ADR_o !== cur.adr || WBs_WE_o !== cur.we || WBs_BYTE_STB_o !== cur.stb ||
                (cur.we && WBs_WR_DAT_o !== cur.wdat) || WBs_STB_o !== 1'b1)
                stable_ok = 1'b0;
            WBs_ACK_i    = (cur.delay >= 0) && (cyc_len == cur.delay + 1);
            WBs_RD_DAT_i = WBs_ACK_i ? cur.rdat : 32'hDEAD_BEEF;
        end else begin
            if (cyc_prev && cur.exp_len > 0) begin
                check("bus_len", 64'(cyc_len), 64'(cur.exp_len));
                check("bus_stable", 64'(stable_ok), 64'd1);
            end
            WBs_ACK_i    = 1'b0;
            WBs_RD_DAT_i = 32'hDEAD_BEEF;
        end
        cyc_prev = WBs_CYC_o;
    end

    // Response monitor: compares each accepted response against the scoreboard.
    always @(negedge WB_CLK) begin
        rsp_t e;
        if (rsp_valid && rsp_ready && !WB_RST) begin
            if (rsp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_response: we=%0b err=%0b rdat=%0h", rsp_we, rsp_err, rsp_rdat);
            end else begin
                e = rsp_q.pop_front();
                check("rsp_we",   64'(rsp_we),   64'(e.we));
                check("rsp_err",  64'(rsp_err),  64'(e.err));
                check("rsp_rdat", 64'(rsp_rdat), 64'(e.rdat));
            end
        end
    end

    // Issue one command; called at posedge+1, returns at posedge+1 after acceptance.
    task automatic push(input logic we, input logic [AW-1:0] adr, input logic [3:0] stb,
                        input logic [DW-1:0] wdat, input int delay, input logic [DW-1:0] rdat,
                        input int exp_len, input logic exp_err, input bit exp_bus, input bit exp_rsp);
        bit ok = 0;
        if (exp_bus) bus_q.push_back('{we: we, adr: adr, stb: stb, wdat: wdat,
                                       delay: delay, rdat: rdat, exp_len: exp_len});
        if (exp_rsp) rsp_q.push_back('{we: we, err: exp_err,
                                       rdat: (we || exp_err) ? '0 : rdat});
        cmd_valid    = 1'b1;
        cmd_we       = we;
        cmd_adr      = adr;
        cmd_byte_stb = stb;
        cmd_wdat     = wdat;
        for (int i = 0; i < 500; i++) begin
            @(negedge WB_CLK);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL push_timeout: cmd_ready=%0b expected 1", cmd_ready);
        end
        @(posedge WB_CLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge WB_CLK);
            if (rsp_q.size() == 0 && !busy_o && !rsp_valid) begin ok = 1; break; end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_drain: pending=%0d expected 0", name, rsp_q.size());
        end
        @(posedge WB_CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        WB_RST = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0;
        cmd_byte_stb = '0; cmd_wdat = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge WB_CLK);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_cyc",       64'(WBs_CYC_o), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy",      64'(busy_o),    64'd0);
        check("rst_adr",       64'(WBs_ADR_o), 64'd0);
        WB_RST = 1'b0;
        @(posedge WB_CLK); #1;

        // 1: write, ACK after 2 wait cycles -> 3 CYC cycles.
        push(1'b1, 17'h00040, 4'hF, 32'hA5A5_1234, 2, 32'h0, 3, 1'b0, 1, 1);
        drain("t1");

        // 2: read, zero-wait ACK -> 1 CYC cycle.
        push(1'b0, 17'h00100, 4'hF, 32'h0, 0, 32'h1234_5678, 1, 1'b0, 1, 1);
        drain("t2");

        // 3: read with no ACK times out after 8 cycles; queued write still runs.
        push(1'b0, 17'h00200, 4'h3, 32'h0, -1, 32'h0, 8, 1'b1, 1, 1);
        push(1'b1, 17'h00204, 4'hC, 32'h0BAD_F00D, 1, 32'h0, 2, 1'b0, 1, 1);
        drain("t3");

        // 4: backpressure with rsp_ready low; 5 commands, depth 4.
        rsp_ready = 1'b0;
        r0 = rises;
        for (int k = 0; k < 5; k++)
            push(k[0], 17'h01000 + 17'(k * 4), 4'hF, 32'h5000_0000 + 32'(k), 1,
                 32'h7700_0000 + 32'(k), 2, 1'b0, 1, 1);
        @(negedge WB_CLK);
        check("bp_cmd_ready_full", 64'(cmd_ready), 64'd0);
        repeat (20) @(negedge WB_CLK);
        check("bp_single_bus_cycle", 64'(rises - r0), 64'd1);
        check("bp_rsp_held", 64'(rsp_valid), 64'd1);
        check("bp_busy", 64'(busy_o), 64'd1);
        @(posedge WB_CLK); #1;
        rsp_ready = 1'b1;
        drain("t4");
        check("bp_total_bus_cycles", 64'(rises - r0), 64'd5);

        // 5: reset while STB is high; in-flight and queued commands vanish.
        push(1'b0, 17'h00300, 4'hF, 32'h0, -1, 32'h0, 0, 1'b0, 1, 0);
        push(1'b1, 17'h00304, 4'hF, 32'h1111_2222, 0, 32'h0, 0, 1'b0, 0, 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge WB_CLK);
            if (WBs_STB_o) break;
        end
        check("rst_mid_stb_seen", 64'(WBs_STB_o), 64'd1);
        @(posedge WB_CLK); #1;
        WB_RST = 1'b1;
        @(posedge WB_CLK); #1;
        check("rst_mid_cyc_low", 64'(WBs_CYC_o), 64'd0);
        check("rst_mid_we_rd_low", 64'({WBs_WE_o, WBs_RD_o}), 64'd0);
        WB_RST = 1'b0;
        r0 = rises;
        repeat (10) @(posedge WB_CLK);
        #1;
        check("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_mid_busy", 64'(busy_o), 64'd0);
        check("rst_mid_no_rsp", 64'(rsp_valid), 64'd0);
        check("rst_mid_no_bus", 64'(rises - r0), 64'd0);

        // 6: ACK on the exact timeout cycle is a success with sampled data.
        push(1'b0, 17'h1FFFC, 4'h1, 32'h0, 7, 32'hCAFE_F00D, 8, 1'b0, 1, 1);
        drain("t6");

        check("scoreboard_bus_empty", 64'(bus_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
